// File: rtl/multiply_unit.sv
// RV32M iterative shift-add multiplier: 32 BUSY steps, result and ready 33 edges after en is first seen.
// Holds result in DONE until advance; flush or reset abandons the operation at any point.
module multiply_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        advance,
  input  logic        flush,
  output logic        ready,
  output logic [31:0] result
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULH  = 2'b01;
  localparam logic [1:0] OP_MULHU = 2'b11;

  logic [1:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic        neg_q, neg_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [63:0] step_add, acc_step, prod;

  always_comb begin
    // Magnitudes of the raw operands; 0x80000000 maps to itself as an unsigned value.
    a_neg    = (op != OP_MULHU) && a[31];
    b_neg    = ((op == OP_MUL) || (op == OP_MULH)) && b[31];
    a_mag    = a_neg ? (~a + 32'd1) : a;
    b_mag    = b_neg ? (~b + 32'd1) : b;
    step_add = mplier_q[cnt_q] ? ({32'd0, mcand_q} << cnt_q) : 64'd0;
    acc_step = acc_q + step_add;
    prod     = neg_q ? (~acc_step + 64'd1) : acc_step;

    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (en && !flush) begin
          state_d  = BUSY;
          op_d     = op;
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = a_neg ^ b_neg;
          acc_d    = 64'd0;
          cnt_d    = 5'd0;
        end
      end
      BUSY: begin
        if (flush || !en) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = DONE;
            result_d = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
          end
        end
      end
      DONE: begin
        if (flush || advance) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 2'b00;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      neg_q    <= 1'b0;
      acc_q    <= 64'd0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign ready  = ready_q;
  assign result = result_q;

endmodule

// File: tb/tb_multiply_unit.sv
// Directed bench for multiply_unit: latency, all four variants, flush/abort/reset, stalls and back-to-back.
module tb_multiply_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        advance;
  logic        flush;
  logic        ready;
  logic [31:0] result;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] last_exp;

  localparam logic [1:0] V_OP [0:8] = '{2'b01, 2'b11, 2'b10, 2'b01, 2'b00,
                                         2'b10, 2'b11, 2'b01, 2'b00};
  localparam logic [31:0] V_A [0:8] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                        32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                                        32'h80000000, 32'hFFFFFFF0, 32'hFFFFFFF0};
  localparam logic [31:0] V_B [0:8] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                        32'h00000002, 32'h00000010, 32'h00000010};
  localparam logic [31:0] V_EXP [0:8] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                          32'h00000000, 32'h80000000, 32'h7FFFFFFE,
                                          32'h00000001, 32'hFFFFFFFF, 32'hFFFFFF00};

  multiply_unit dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .op      (op),
    .a       (a),
    .b       (b),
    .advance (advance),
    .flush   (flush),
    .ready   (ready),
    .result  (result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Called at a negedge with the unit idle; returns edges counted until ready is seen.
  task automatic run_to_ready(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                              output int lat);
    op = o; a = x; b = y; en = 1'b1; lat = 0;
    while (ready !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic end_op();
    advance = 1'b1; en = 1'b0;
    @(negedge clk);
    advance = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1; en = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5; advance = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL reset_result: got %h want 00000000", result); else pass_cnt++;
    rst = 1'b0;
    run_to_ready(2'b00, 32'd3, 32'd5, lat);
    total_cnt++; if (lat !== 33) $display("FAIL first_start_latency: got %0d want 33", lat); else pass_cnt++;
    total_cnt++; if (result !== 32'd15) $display("FAIL first_start_result: got %h want 0000000f", result); else pass_cnt++;
    end_op();
    total_cnt++; if (ready !== 1'b0) $display("FAIL first_start_drop: got %b want 0", ready); else pass_cnt++;
  endtask

  task automatic test_mul_basic();
    int lat;
    run_to_ready(2'b00, 32'd7, 32'hFFFFFFFD, lat);
    total_cnt++; if (lat !== 33) $display("FAIL mul_latency: got %0d want 33", lat); else pass_cnt++;
    total_cnt++; if (result !== 32'hFFFFFFEB) $display("FAIL mul_result: got %h want ffffffeb", result); else pass_cnt++;
    // Stall in DONE while en/operands wiggle; nothing should move.
    for (int i = 0; i < 5; i++) begin
      op = 2'b11; a = 32'h1234_0000 + i; b = 32'h55; en = i[0];
      @(negedge clk);
      total_cnt++;
      if (ready !== 1'b1 || result !== 32'hFFFFFFEB)
        $display("FAIL mul_stall_%0d: got ready=%b result=%h want ready=1 result=ffffffeb", i, ready, result);
      else pass_cnt++;
    end
    end_op();
    total_cnt++; if (ready !== 1'b0) $display("FAIL mul_advance_drop: got %b want 0", ready); else pass_cnt++;
    total_cnt++; if (result !== 32'hFFFFFFEB) $display("FAIL mul_result_after_advance: got %h want ffffffeb", result); else pass_cnt++;
  endtask

  task automatic test_variants();
    int lat;
    for (int i = 0; i < 9; i++) begin
      run_to_ready(V_OP[i], V_A[i], V_B[i], lat);
      total_cnt++;
      if (lat !== 33 || result !== V_EXP[i])
        $display("FAIL variant_%0d: got lat=%0d result=%h want lat=33 result=%h", i, lat, result, V_EXP[i]);
      else pass_cnt++;
      end_op();
    end
    last_exp = V_EXP[8];
  endtask

  task automatic test_flush_busy();
    int lat;
    op = 2'b00; a = 32'd5; b = 32'd6; en = 1'b1;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; en = 1'b0;
    total_cnt++; if (ready !== 1'b0) $display("FAIL flush_busy_ready: got %b want 0", ready); else pass_cnt++;
    total_cnt++; if (result !== last_exp) $display("FAIL flush_busy_result: got %h want %h", result, last_exp); else pass_cnt++;
    repeat (30) @(negedge clk);
    total_cnt++; if (ready !== 1'b0) $display("FAIL flush_busy_stays_idle: got %b want 0", ready); else pass_cnt++;
    run_to_ready(2'b00, 32'd3, 32'd4, lat);
    total_cnt++; if (lat !== 33) $display("FAIL flush_restart_latency: got %0d want 33", lat); else pass_cnt++;
    total_cnt++; if (result !== 32'h0000000C) $display("FAIL flush_restart_result: got %h want 0000000c", result); else pass_cnt++;
    end_op();
  endtask

  task automatic test_flush_done();
    int lat;
    run_to_ready(2'b00, 32'h11, 32'h11, lat);
    flush = 1'b1; en = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    total_cnt++; if (ready !== 1'b0) $display("FAIL flush_done_ready: got %b want 0", ready); else pass_cnt++;
    total_cnt++; if (result !== 32'h121) $display("FAIL flush_done_result: got %h want 00000121", result); else pass_cnt++;
  endtask

  task automatic test_abort_en();
    int lat;
    logic seen;
    seen = 1'b0;
    op = 2'b00; a = 32'd5; b = 32'd5; en = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready === 1'b1) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL abort_en_ready: got 1 want 0"); else pass_cnt++;
    run_to_ready(2'b00, 32'd4, 32'd4, lat);
    total_cnt++;
    if (lat !== 33 || result !== 32'd16)
      $display("FAIL abort_restart: got lat=%0d result=%h want lat=33 result=00000010", lat, result);
    else pass_cnt++;
    end_op();
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    run_to_ready(2'b00, 32'd2, 32'd3, lat);
    total_cnt++;
    if (lat !== 33 || result !== 32'd6)
      $display("FAIL b2b_first: got lat=%0d result=%h want lat=33 result=00000006", lat, result);
    else pass_cnt++;
    advance = 1'b1;
    @(negedge clk);
    gap = 1;
    advance = 1'b0;
    total_cnt++; if (ready !== 1'b0) $display("FAIL b2b_drop: got %b want 0", ready); else pass_cnt++;
    op = 2'b00; a = 32'h10000; b = 32'h10000; en = 1'b1;
    while (ready !== 1'b1 && gap < 60) begin
      @(negedge clk);
      gap++;
    end
    total_cnt++; if (gap !== 34) $display("FAIL b2b_gap: got %0d want 34", gap); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL b2b_second: got %h want 00000000", result); else pass_cnt++;
    end_op();
  endtask

  task automatic test_operand_change();
    int lat;
    op = 2'b00; a = 32'h1234; b = 32'h10; en = 1'b1; lat = 0;
    repeat (10) begin
      @(negedge clk);
      lat++;
    end
    a = 32'hDEADBEEF; b = 32'h0F0F0F0F; op = 2'b11;
    while (ready !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    total_cnt++; if (lat !== 33) $display("FAIL opchange_latency: got %0d want 33", lat); else pass_cnt++;
    total_cnt++; if (result !== 32'h12340) $display("FAIL opchange_result: got %h want 00012340", result); else pass_cnt++;
    end_op();
  endtask

  task automatic test_reset_mid();
    int lat;
    op = 2'b00; a = 32'd9; b = 32'd9; en = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    total_cnt++; if (ready !== 1'b0) $display("FAIL reset_mid_ready: got %b want 0", ready); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL reset_mid_result: got %h want 00000000", result); else pass_cnt++;
    @(negedge clk);
    run_to_ready(2'b00, 32'h100, 32'd3, lat);
    total_cnt++;
    if (lat !== 33 || result !== 32'h300)
      $display("FAIL reset_mid_restart: got lat=%0d result=%h want lat=33 result=00000300", lat, result);
    else pass_cnt++;
    end_op();
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_variants();
    test_flush_busy();
    test_flush_done();
    test_abort_en();
    test_back_to_back();
    test_operand_change();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
